urv_pipe_ctrl: RTL and testbench
================================

Name: urv_pipe_ctrl

Overview:
- Parametrised pipeline control unit for uRV-class cores.
- Replaces hard-wired stall/kill glue with a generic N-stage, one-branch-stage controller.
- Derives per-stage stall and kill strobes from per-stage stall requests and a taken-branch strobe.
- Adds branch-shadow tracking of configurable depth, saturating performance counters and a stall watchdog.
- Sits at CPU top level between the fetch/decode/exec/writeback stages.

Parameters:
- g_num_stages, 4, number of pipeline stages N (index 0 = fetch, N-1 = writeback); range 2..8.
- g_branch_stage, 2, index B of the stage that resolves branches; range 1..N-1.
- g_self_stall_mask, 4'b0100, N bits; bit i set = stage i's own request also stalls stage i.
- g_cnt_width, 32, width of each performance counter; range 8..40.
- g_stall_timeout, 0, consecutive fetch-stall cycles that trip the watchdog; 0 disables it.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_req_i  in  N  per-stage stall request.
- branch_i  in  1  taken branch/jump from stage B (same as the branch-take strobe to fetch).
- stall_o  out  N  per-stage hold.
- kill_o  out  N  per-stage invalidate.
- perf_clr_i  in  1  synchronous clear of counters and watchdog.
- perf_stall_cnt_o  out  g_cnt_width  cycles with stall_o[0]=1.
- perf_kill_cnt_o  out  g_cnt_width  cycles with kill_o[B]=1.
- perf_branch_cnt_o  out  g_cnt_width  retired taken branches.
- timeout_o  out  1  sticky watchdog flag.

Behaviour:
- Stall, combinational: stall_o[i] = OR(stall_req_i[j], j>i) | (stall_req_i[i] & g_self_stall_mask[i]).
  - Defaults reproduce the current core: F = D|X|W, D = X|W, X = X|W, W = 0.
- Branch shadow: register sh[B-1:0], reset 0.
  - When stall_o[B]=0: sh[0] <= branch_i, sh[k] <= sh[k-1].
  - When stall_o[B]=1: sh holds.
- Kill, combinational:
  - kill_o[s] = branch_i | OR(sh[k], k<s) for 1<=s<=B.
  - kill_o[0] = 0; kill_o[s>B] = 0.
  - Defaults give D = bra|sh0 and X = bra|sh0|sh1.
- Branch during stall: kill_o reflects branch_i immediately. The shadow captures it only on the first non-stalled cycle.
  - A branch held high across k stall cycles counts and shifts once.
- Back-to-back branches: the shadow ORs naturally. Kill persists B cycles after the last non-stalled branch.
- perf_stall_cnt_o: increments in cycles where stall_o[0]=1.
- perf_kill_cnt_o: increments in cycles where kill_o[B]=1.
- perf_branch_cnt_o: increments in cycles where branch_i=1 and stall_o[B]=0.
- All counters:
  - Saturate at all-ones and never wrap.
  - perf_clr_i has priority over increment; the clear takes effect next edge, output 0 the following cycle.
- Watchdog (g_stall_timeout>0):
  - Counter wd counts consecutive cycles of stall_o[0]=1 and saturates at g_stall_timeout.
  - wd clears to 0 on any cycle with stall_o[0]=0.
  - timeout_o is set on the edge where wd reaches g_stall_timeout, i.e. high after exactly g_stall_timeout consecutive stall cycles.
  - timeout_o stays set until perf_clr_i or reset.
  - With g_stall_timeout=0, timeout_o is tied 0 and no wd logic exists.
- Reset: asynchronous assert clears sh, all counters, wd and timeout_o to 0.
  - stall_o and kill_o then follow inputs combinationally, with sh=0.
  - Reset mid-shadow drops pending kills.
  - Deassert is synchronised externally.
- Elaboration: illegal parameter ranges raise an error.

Test Plan:
- Defaults, stall_req_i=4'b0100 (X) for 3 cycles -> stall_o=4'b0111 each cycle; perf_stall_cnt_o=3; kill_o=0.
- Defaults, one-cycle branch_i, no stalls:
  - kill_o = 4'b0110 at cycle 0, 4'b0110 at cycle 1, 4'b0100 at cycle 2, 0 at cycle 3.
  - perf_branch_cnt_o=1; perf_kill_cnt_o=3.
- Defaults, branch_i high with stall_req_i[3]=1 for 2 cycles, then released:
  - kill_o[2:1]=2'b11 throughout.
  - The shadow starts only after release, so kills persist 2 more cycles.
  - perf_branch_cnt_o=1.
- g_num_stages=6, g_branch_stage=4, single branch -> kill_o[4] high for 5 cycles, kill_o[1] for 2; kill_o[5]=kill_o[0]=0.
- g_stall_timeout=5:
  - stall_req_i[1]=1 for 4 cycles, 1 idle, then 5 cycles -> timeout_o stays 0 after the first burst, rises after the 5th cycle of the second burst.
  - timeout_o stays high until perf_clr_i pulses.
- g_cnt_width=8, 300 stall cycles -> perf_stall_cnt_o=255 (saturated); perf_clr_i concurrent with a stall -> 0 next cycle; async rst_i mid-shadow -> kill_o drops immediately.

Source files
------------

// File: rtl/urv_pipe_ctrl_if.sv
// Bundle of stall/kill/perf signals between the uRV pipeline stages and
// the pipeline controller. The controller takes the slave side; the CPU
// top level (or a bench) takes the master side.
interface urv_pipe_ctrl_if #(
    parameter int g_num_stages = 4,
    parameter int g_cnt_width  = 32
);
    logic [g_num_stages-1:0] stall_req_i;
    logic                    branch_i;
    logic                    perf_clr_i;
    logic [g_num_stages-1:0] stall_o;
    logic [g_num_stages-1:0] kill_o;
    logic [g_cnt_width-1:0]  perf_stall_cnt_o;
    logic [g_cnt_width-1:0]  perf_kill_cnt_o;
    logic [g_cnt_width-1:0]  perf_branch_cnt_o;
    logic                    timeout_o;

    modport master (
        output stall_req_i, branch_i, perf_clr_i,
        input  stall_o, kill_o, perf_stall_cnt_o, perf_kill_cnt_o,
               perf_branch_cnt_o, timeout_o
    );

    modport slave (
        input  stall_req_i, branch_i, perf_clr_i,
        output stall_o, kill_o, perf_stall_cnt_o, perf_kill_cnt_o,
               perf_branch_cnt_o, timeout_o
    );
endinterface

// File: rtl/urv_pipe_ctrl.sv
// Generic N-stage pipeline controller for uRV-class cores.
// Stall and kill strobes are combinational from the requests, the branch
// strobe and a small branch-shadow shift register; counters and the stall
// watchdog are registered.
module urv_pipe_ctrl #(
    parameter int                    g_num_stages      = 4,
    parameter int                    g_branch_stage    = 2,
    parameter logic [g_num_stages-1:0] g_self_stall_mask = 4'b0100,
    parameter int                    g_cnt_width       = 32,
    parameter int                    g_stall_timeout   = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    urv_pipe_ctrl_if.slave    bus
);

    localparam logic [g_cnt_width-1:0] CNT_MAX = {g_cnt_width{1'b1}};

    // Reject parameter combinations the controller cannot implement.
    if (g_num_stages < 2 || g_num_stages > 8) begin : g_bad_num_stages
        $error("urv_pipe_ctrl: g_num_stages must be in 2..8");
    end
    if (g_branch_stage < 1 || g_branch_stage > g_num_stages - 1) begin : g_bad_branch_stage
        $error("urv_pipe_ctrl: g_branch_stage must be in 1..g_num_stages-1");
    end
    if (g_cnt_width < 8 || g_cnt_width > 40) begin : g_bad_cnt_width
        $error("urv_pipe_ctrl: g_cnt_width must be in 8..40");
    end
    if (g_stall_timeout < 0) begin : g_bad_timeout
        $error("urv_pipe_ctrl: g_stall_timeout must be >= 0");
    end

    // Saturating increment: never wraps past all-ones.
    function automatic logic [g_cnt_width-1:0] sat_inc(
        input logic [g_cnt_width-1:0] cnt,
        input logic                   en
    );
        if (en && (cnt != CNT_MAX)) begin
            return cnt + {{(g_cnt_width-1){1'b0}}, 1'b1};
        end else begin
            return cnt;
        end
    endfunction

    logic [g_num_stages-1:0]   stall_s;
    logic [g_num_stages-1:0]   kill_s;
    logic                      kill_acc_s;
    logic                      branch_adv_s;
    logic                      timeout_s;
    logic [g_branch_stage-1:0] sh_r;
    logic [g_cnt_width-1:0]    stall_cnt_r;
    logic [g_cnt_width-1:0]    kill_cnt_r;
    logic [g_cnt_width-1:0]    branch_cnt_r;

    // A stage holds when any later stage requests a stall, or when its own
    // request is configured to hold itself.
    always_comb begin
        stall_s = {g_num_stages{1'b0}};
        for (int i = 0; i < g_num_stages; i++) begin
            stall_s[i] = bus.stall_req_i[i] & g_self_stall_mask[i];
            for (int j = i + 1; j < g_num_stages; j++) begin
                stall_s[i] = stall_s[i] | bus.stall_req_i[j];
            end
        end
    end

    // Stages 1..B are killed by a live branch or by any older shadow bit that
    // has not yet drained past them; fetch and post-branch stages never are.
    always_comb begin
        kill_s     = {g_num_stages{1'b0}};
        kill_acc_s = bus.branch_i;
        for (int s = 1; s <= g_branch_stage; s++) begin
            kill_acc_s = kill_acc_s | sh_r[s-1];
            kill_s[s]  = kill_acc_s;
        end
    end

    // A branch is only taken into the shadow (and counted) once the branch
    // stage actually advances.
    assign branch_adv_s = bus.branch_i & ~stall_s[g_branch_stage];

    // Branch shadow: shifts only while the branch stage advances.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_r <= {g_branch_stage{1'b0}};
        end else if (!stall_s[g_branch_stage]) begin
            sh_r[0] <= bus.branch_i;
            for (int k = 1; k < g_branch_stage; k++) begin
                sh_r[k] <= sh_r[k-1];
            end
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r  <= {g_cnt_width{1'b0}};
            kill_cnt_r   <= {g_cnt_width{1'b0}};
            branch_cnt_r <= {g_cnt_width{1'b0}};
        end else if (bus.perf_clr_i) begin
            stall_cnt_r  <= {g_cnt_width{1'b0}};
            kill_cnt_r   <= {g_cnt_width{1'b0}};
            branch_cnt_r <= {g_cnt_width{1'b0}};
        end else begin
            stall_cnt_r  <= sat_inc(stall_cnt_r, stall_s[0]);
            kill_cnt_r   <= sat_inc(kill_cnt_r, kill_s[g_branch_stage]);
            branch_cnt_r <= sat_inc(branch_cnt_r, branch_adv_s);
        end
    end

    if (g_stall_timeout > 0) begin : g_wd
        localparam int WD_W = $clog2(g_stall_timeout + 1);
        localparam logic [WD_W-1:0] WD_MAX = WD_W'(g_stall_timeout);
        localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

        logic [WD_W-1:0] wd_r;
        logic            timeout_r;

        // Count consecutive fetch-stall cycles; the flag trips on the edge
        // where the count reaches the limit and then sticks until cleared.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                wd_r      <= {WD_W{1'b0}};
                timeout_r <= 1'b0;
            end else if (bus.perf_clr_i) begin
                wd_r      <= {WD_W{1'b0}};
                timeout_r <= 1'b0;
            end else if (stall_s[0]) begin
                if (wd_r != WD_MAX) begin
                    wd_r <= wd_r + WD_ONE;
                end
                if (wd_r == WD_MAX - WD_ONE) begin
                    timeout_r <= 1'b1;
                end
            end else begin
                wd_r <= {WD_W{1'b0}};
            end
        end

        assign timeout_s = timeout_r;
    end else begin : g_no_wd
        assign timeout_s = 1'b0;
    end

    assign bus.stall_o           = stall_s;
    assign bus.kill_o            = kill_s;
    assign bus.perf_stall_cnt_o  = stall_cnt_r;
    assign bus.perf_kill_cnt_o   = kill_cnt_r;
    assign bus.perf_branch_cnt_o = branch_cnt_r;
    assign bus.timeout_o         = timeout_s;

endmodule

// File: tb/tb_urv_pipe_ctrl.sv
// Directed bench for urv_pipe_ctrl: default 4-stage core, a 6-stage core
// with late branch resolution, and an 8-bit-counter core with the watchdog.
module tb_urv_pipe_ctrl;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk_i = ~clk_i;

    urv_pipe_ctrl_if #(.g_num_stages(4), .g_cnt_width(32)) if_def ();
    urv_pipe_ctrl_if #(.g_num_stages(6), .g_cnt_width(32)) if_wide ();
    urv_pipe_ctrl_if #(.g_num_stages(4), .g_cnt_width(8))  if_wd ();

    urv_pipe_ctrl u_dut_def (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (if_def)
    );

    urv_pipe_ctrl #(
        .g_num_stages      (6),
        .g_branch_stage    (4),
        .g_self_stall_mask (6'b010000),
        .g_cnt_width       (32),
        .g_stall_timeout   (0)
    ) u_dut_wide (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (if_wide)
    );

    urv_pipe_ctrl #(
        .g_num_stages      (4),
        .g_branch_stage    (2),
        .g_self_stall_mask (4'b0100),
        .g_cnt_width       (8),
        .g_stall_timeout   (5)
    ) u_dut_wd (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (if_wd)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_all();
        if_def.stall_req_i  = 4'b0000;
        if_def.branch_i     = 1'b0;
        if_def.perf_clr_i   = 1'b0;
        if_wide.stall_req_i = 6'b000000;
        if_wide.branch_i    = 1'b0;
        if_wide.perf_clr_i  = 1'b0;
        if_wd.stall_req_i   = 4'b0000;
        if_wd.branch_i      = 1'b0;
        if_wd.perf_clr_i    = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_k4 [6];
        logic [5:0] exp_k6 [6];

        idle_all();
        rst_i = 1'b1;
        tick();
        tick();
        check_eq("rst_def_stall_cnt", 64'(if_def.perf_stall_cnt_o), 64'd0);
        check_eq("rst_def_branch_cnt", 64'(if_def.perf_branch_cnt_o), 64'd0);
        check_eq("rst_def_kill", 64'(if_def.kill_o), 64'd0);
        check_eq("rst_wd_timeout", 64'(if_wd.timeout_o), 64'd0);
        rst_i = 1'b0;
        tick();

        // Execute-stage stall for 3 cycles.
        for (int c = 0; c < 3; c++) begin
            if_def.stall_req_i = 4'b0100;
            #1;
            check_eq("x_stall_stall_o", 64'(if_def.stall_o), 64'h7);
            check_eq("x_stall_kill_o", 64'(if_def.kill_o), 64'h0);
            tick();
        end
        if_def.stall_req_i = 4'b0000;
        check_eq("x_stall_cnt", 64'(if_def.perf_stall_cnt_o), 64'd3);
        check_eq("def_timeout_tied", 64'(if_def.timeout_o), 64'd0);

        // Writeback-only request stalls F/D/X but never W itself.
        if_def.stall_req_i = 4'b1000;
        #1;
        check_eq("w_req_stall_o", 64'(if_def.stall_o), 64'h7);
        if_def.stall_req_i = 4'b0010;
        #1;
        check_eq("d_req_stall_o", 64'(if_def.stall_o), 64'h1);
        if_def.stall_req_i = 4'b0000;
        tick();
        check_eq("req_probe_no_cnt", 64'(if_def.perf_stall_cnt_o), 64'd3);

        // Single branch, no stalls.
        exp_k4 = '{4'b0110, 4'b0110, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        for (int c = 0; c < 4; c++) begin
            if_def.branch_i = (c == 0);
            #1;
            check_eq($sformatf("br1_kill_c%0d", c), 64'(if_def.kill_o), 64'(exp_k4[c]));
            tick();
        end
        check_eq("br1_branch_cnt", 64'(if_def.perf_branch_cnt_o), 64'd1);
        check_eq("br1_kill_cnt", 64'(if_def.perf_kill_cnt_o), 64'd3);

        // Branch held across a 2-cycle writeback stall, taken on release.
        exp_k4 = '{4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0000};
        for (int c = 0; c < 6; c++) begin
            if_def.branch_i    = (c < 3);
            if_def.stall_req_i = (c < 2) ? 4'b1000 : 4'b0000;
            #1;
            check_eq($sformatf("brst_kill_c%0d", c), 64'(if_def.kill_o), 64'(exp_k4[c]));
            tick();
        end
        check_eq("brst_branch_cnt", 64'(if_def.perf_branch_cnt_o), 64'd2);
        check_eq("brst_kill_cnt", 64'(if_def.perf_kill_cnt_o), 64'd8);
        check_eq("brst_stall_cnt", 64'(if_def.perf_stall_cnt_o), 64'd5);

        // Six stages, branch resolved in stage 4.
        exp_k6 = '{6'h1E, 6'h1E, 6'h1C, 6'h18, 6'h10, 6'h00};
        for (int c = 0; c < 6; c++) begin
            if_wide.branch_i = (c == 0);
            #1;
            check_eq($sformatf("wide_kill_c%0d", c), 64'(if_wide.kill_o), 64'(exp_k6[c]));
            tick();
        end
        check_eq("wide_branch_cnt", 64'(if_wide.perf_branch_cnt_o), 64'd1);
        check_eq("wide_kill_cnt", 64'(if_wide.perf_kill_cnt_o), 64'd5);

        // Watchdog: 4-cycle burst, one idle, then 5-cycle burst trips it.
        for (int c = 0; c < 4; c++) begin
            if_wd.stall_req_i = 4'b0010;
            #1;
            if (c == 0) begin
                check_eq("wd_stall_o", 64'(if_wd.stall_o), 64'h1);
            end
            tick();
        end
        check_eq("wd_burst1_timeout", 64'(if_wd.timeout_o), 64'd0);
        if_wd.stall_req_i = 4'b0000;
        tick();
        check_eq("wd_idle_timeout", 64'(if_wd.timeout_o), 64'd0);
        for (int c = 0; c < 5; c++) begin
            if_wd.stall_req_i = 4'b0010;
            tick();
            check_eq($sformatf("wd_burst2_c%0d", c), 64'(if_wd.timeout_o), 64'(c == 4));
        end
        if_wd.stall_req_i = 4'b0000;
        tick();
        tick();
        tick();
        check_eq("wd_sticky", 64'(if_wd.timeout_o), 64'd1);
        check_eq("wd_stall_cnt", 64'(if_wd.perf_stall_cnt_o), 64'd9);
        if_wd.perf_clr_i = 1'b1;
        #1;
        check_eq("wd_clr_not_yet", 64'(if_wd.timeout_o), 64'd1);
        tick();
        if_wd.perf_clr_i = 1'b0;
        check_eq("wd_clr_timeout", 64'(if_wd.timeout_o), 64'd0);
        check_eq("wd_clr_stall_cnt", 64'(if_wd.perf_stall_cnt_o), 64'd0);

        // 8-bit counter saturation over 300 stall cycles.
        if_wd.stall_req_i = 4'b0010;
        for (int c = 0; c < 300; c++) begin
            tick();
        end
        check_eq("sat_stall_cnt", 64'(if_wd.perf_stall_cnt_o), 64'hFF);
        check_eq("sat_timeout", 64'(if_wd.timeout_o), 64'd1);
        if_wd.perf_clr_i = 1'b1;
        tick();
        if_wd.perf_clr_i = 1'b0;
        check_eq("clr_vs_stall_cnt", 64'(if_wd.perf_stall_cnt_o), 64'd0);
        check_eq("clr_vs_stall_timeout", 64'(if_wd.timeout_o), 64'd0);
        tick();
        check_eq("post_clr_stall_cnt", 64'(if_wd.perf_stall_cnt_o), 64'd1);
        check_eq("post_clr_timeout", 64'(if_wd.timeout_o), 64'd0);
        if_wd.stall_req_i = 4'b0000;
        tick();

        // Asynchronous reset in the middle of a branch shadow.
        if_def.branch_i = 1'b1;
        tick();
        if_def.branch_i = 1'b0;
        #1;
        check_eq("rst_mid_kill_before", 64'(if_def.kill_o), 64'h6);
        rst_i = 1'b1;
        #1;
        check_eq("rst_mid_kill_after", 64'(if_def.kill_o), 64'h0);
        check_eq("rst_mid_branch_cnt", 64'(if_def.perf_branch_cnt_o), 64'd0);
        check_eq("rst_mid_kill_cnt", 64'(if_def.perf_kill_cnt_o), 64'd0);
        #1;
        rst_i = 1'b0;
        tick();
        check_eq("rst_mid_kill_next", 64'(if_def.kill_o), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
